keccak_round_sequencer: RTL and testbench
=========================================

// Module: keccak_round_sequencer
// PURPOSE
//   Parametrised multi-round sequencer for the Keccak-f permutation datapath.
//   Drives the five step engines (theta, rho, pi, chi, iota) through one shared start/done handshake.
//   Iterates each step over its slice or lane index, then loops for NUM_ROUNDS rounds.
//   Adds round tracking, abort and a per-step watchdog timeout.
// PARAMETERS
//   LANE_W      64   z-dimension depth; theta and chi are issued once per slice, z = 0..LANE_W-1
//   LANES       25   lanes per slice; rho is issued once per lane, 0..LANES-1
//   NUM_ROUNDS  24   rounds per permutation (>=1)
//   TIMEOUT     255  max WAIT cycles per step iteration; 0 disables the watchdog
//   IDX_W       clog2(max(LANE_W,LANES))  width of step_idx (derived)
//   RND_W       clog2(NUM_ROUNDS)         width of round_idx (derived, min 1)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      begin permutation; sampled only in IDLE or ERR
//   abort      in   1      cancel the run in progress; wins over every other event
//   step_done  in   1      engine finished the current iteration (pulse or level)
//   step_start out  1      one-cycle pulse that launches one engine iteration
//   step_id    out  3      0=theta 1=rho 2=pi 3=chi 4=iota; stable from ISSUE to end of WAIT
//   step_idx   out  IDX_W  slice (theta/chi), lane (rho), 0 (pi/iota)
//   round_idx  out  RND_W  current round, 0..NUM_ROUNDS-1; feeds the iota RC lookup
//   busy       out  1      high in every state except IDLE and ERR
//   done       out  1      one-cycle pulse after the last iota of the last round
//   error      out  1      watchdog expired; sticky until start or rst
// BEHAVIOUR
//   Reset: state=IDLE. step_start, step_id, step_idx, round_idx, busy, done, error, wait_cnt all 0.
//   FSM states: IDLE, ISSUE, WAIT, ADV, FINISH, ERR.
//   IDLE: on start -> ISSUE with step=theta, idx=0, round=0.
//   ISSUE: step_start=1 for exactly one cycle; wait_cnt cleared; -> WAIT.
//     step_done in the ISSUE cycle is ignored.
//   WAIT: step_done=1 -> ADV.
//     Otherwise wait_cnt++; when wait_cnt==TIMEOUT-1 (TIMEOUT!=0) -> ERR.
//   ADV: iteration counts per step are theta LANE_W, rho LANES, pi 1, chi LANE_W, iota 1.
//     idx < count-1: idx++, -> ISSUE.
//     Else idx=0 and step advances; after iota, step=theta and round++.
//     If iota completes round NUM_ROUNDS-1 -> FINISH; otherwise -> ISSUE.
//   FINISH: done=1 for one cycle; round_idx and step_idx cleared; -> IDLE.
//   ERR: error=1, busy=0, step_start=0.
//     On start: error clears, -> ISSUE as from IDLE.
//   abort in any state other than IDLE: -> IDLE next edge.
//     Counters cleared; no done; error cleared.
//   start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
//   Minimum 3 cycles per iteration (ISSUE, WAIT, ADV) with zero-latency engines.
//     Total = 3*NUM_ROUNDS*(2*LANE_W+LANES+2) + 1 (FINISH).
//   Counter wrap: idx and round compare against count-1 and never wrap.
//     No index ever exceeds its range.
//   rst mid-run: immediate return to reset values. No done or error pulse on release.
//   All outputs registered; no combinational path from any input to any output.
// TESTING
//   Bench params: LANE_W=4, LANES=25, NUM_ROUNDS=2, TIMEOUT=8.
//   T1 full run, engine answers step_done in the first WAIT cycle
//      -> exactly 70 step_start pulses; done high in the 211th cycle after the start edge.
//   T2 step order/index
//      -> round 0 pulses: theta idx 0..3, rho 0..24, pi 0, chi 0..3, iota 0 with round_idx=0;
//         round 1 repeats the sequence with round_idx=1.
//   T3 engine never answers on rho idx 7
//      -> error=1 after 8 WAIT cycles; busy=0; no further step_start;
//         next start clears error and restarts at theta idx 0, round 0.
//   T4 abort asserted during chi idx 2, round 1
//      -> IDLE next edge, busy=0, done never pulses; all index outputs 0.
//   T5 start pulsed every cycle throughout a run; step_done delayed 5 cycles
//      -> no restart; 70 pulses; done once; every iteration lasts 7 cycles.
//   T6 rst asserted in WAIT, then released
//      -> all outputs 0 immediately; no done or error; next start runs cleanly to done.

Source files
------------

// File: rtl/keccak_round_sequencer_if.sv
// keccak_round_sequencer_if: start/done handshake between the Keccak round sequencer and its step engines
interface keccak_round_sequencer_if #(
  parameter int IDX_W = 6,
  parameter int RND_W = 5
);
  logic start, abort, step_done, step_start, busy, done, error;
  logic [2:0] step_id;
  logic [IDX_W-1:0] step_idx;
  logic [RND_W-1:0] round_idx;
  modport master(
    output start, abort, step_done,
    input step_start, step_id, step_idx, round_idx, busy, done, error
  );
  modport slave(
    input start, abort, step_done,
    output step_start, step_id, step_idx, round_idx, busy, done, error
  );
endinterface

// File: rtl/keccak_round_sequencer.sv
// keccak_round_sequencer: walks theta/rho/pi/chi/iota engine iterations over NUM_ROUNDS rounds with abort and watchdog
module keccak_round_sequencer #(
  parameter int LANE_W = 64,
  parameter int LANES = 25,
  parameter int NUM_ROUNDS = 24,
  parameter int TIMEOUT = 255,
  parameter int IDX_W = (LANE_W > LANES ? LANE_W : LANES) > 1 ? $clog2(LANE_W > LANES ? LANE_W : LANES) : 1,
  parameter int RND_W = NUM_ROUNDS > 1 ? $clog2(NUM_ROUNDS) : 1
) (
  input logic clk,
  input logic rst,
  keccak_round_sequencer_if.slave bus
);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADV, FINISH, ERR} state_t;
  typedef enum logic [2:0] {THETA, RHO, PI, CHI, IOTA} step_t;
  state_t state, state_n;
  step_t step, step_n;
  logic [IDX_W-1:0] idx, idx_n, last;
  logic [RND_W-1:0] rnd, rnd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic step_start, busy, done, error;
  logic step_end, round_end, perm_end;
  always_comb begin
    state_n = state;
    step_n = step;
    idx_n = idx;
    rnd_n = rnd;
    cnt_n = cnt;
    last = (step == THETA || step == CHI) ? IDX_W'(LANE_W - 1) : step == RHO ? IDX_W'(LANES - 1) : '0;
    step_end = idx == last;
    round_end = step_end && step == IOTA;
    perm_end = round_end && rnd == RND_W'(NUM_ROUNDS - 1);
    case (state)
      IDLE, ERR: if (bus.start) begin
        state_n = ISSUE;
        step_n = THETA;
        idx_n = '0;
        rnd_n = '0;
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: if (bus.step_done) state_n = ADV;
        else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) state_n = ERR;
        else cnt_n = cnt + 1'b1;
      ADV: begin
        state_n = perm_end ? FINISH : ISSUE;
        idx_n = step_end ? '0 : idx + 1'b1;
        step_n = !step_end ? step : round_end ? THETA : step_t'(step + 3'd1);
        rnd_n = round_end && !perm_end ? rnd + 1'b1 : rnd;
      end
      FINISH: begin
        state_n = IDLE;
        idx_n = '0;
        rnd_n = '0;
      end
      default: state_n = IDLE;
    endcase
    if (bus.abort) begin
      state_n = IDLE;
      step_n = THETA;
      idx_n = '0;
      rnd_n = '0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      step <= THETA;
      idx <= '0;
      rnd <= '0;
      cnt <= '0;
      step_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      step <= step_n;
      idx <= idx_n;
      rnd <= rnd_n;
      cnt <= cnt_n;
      step_start <= state_n == ISSUE;
      busy <= state_n != IDLE && state_n != ERR;
      done <= state_n == FINISH;
      error <= state_n == ERR;
    end
  assign bus.step_start = step_start;
  assign bus.step_id = step;
  assign bus.step_idx = idx;
  assign bus.round_idx = rnd;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.error = error;
endmodule

// File: tb/tb_keccak_round_sequencer.sv
// tb_keccak_round_sequencer: randomized engine responder and scenario checks against a loop-built step sequence model
module tb_keccak_round_sequencer;
  localparam int LANE_W = 4;
  localparam int LANES = 25;
  localparam int NUM_ROUNDS = 2;
  localparam int TIMEOUT = 8;
  localparam int IDX_W = 5;
  localparam int RND_W = 1;
  localparam int PULSES = NUM_ROUNDS * (2 * LANE_W + LANES + 2);
  typedef struct {int id; int idx; int rnd; int cyc;} rec_t;
  logic clk = 0;
  logic rst = 0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fix_delay = 1;
  bit rand_delay = 0;
  int stall_id = 7;
  int stall_idx = 0;
  int delays[$];
  rec_t recs[$];
  rec_t exp_q[$];
  keccak_round_sequencer_if #(.IDX_W(IDX_W), .RND_W(RND_W)) bus();
  keccak_round_sequencer #(.LANE_W(LANE_W), .LANES(LANES), .NUM_ROUNDS(NUM_ROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (bus.step_start) recs.push_back('{int'(bus.step_id), int'(bus.step_idx), int'(bus.round_idx), cyc});
    if (bus.done) done_cnt++;
  end
  initial begin
    int wcnt, cur;
    bit pend, stalled;
    wcnt = 0;
    cur = 1;
    pend = 0;
    stalled = 0;
    bus.step_done = 0;
    forever begin
      @(negedge clk);
      bus.step_done = 0;
      if (bus.step_start) begin
        pend = 1;
        wcnt = 0;
        cur = rand_delay ? int'($urandom_range(1, 4)) : fix_delay;
        stalled = int'(bus.step_id) == stall_id && int'(bus.step_idx) == stall_idx;
        if (!stalled) delays.push_back(cur);
      end else if (pend && !stalled) begin
        wcnt++;
        if (wcnt == cur) begin
          bus.step_done = 1;
          pend = 0;
        end
      end
    end
  end
  function automatic void build_exp();
    exp_q.delete();
    for (int r = 0; r < NUM_ROUNDS; r++)
      for (int s = 0; s < 5; s++)
        for (int i = 0; i < ((s == 0 || s == 3) ? LANE_W : (s == 1) ? LANES : 1); i++)
          exp_q.push_back('{s, i, r, 0});
  endfunction
  task automatic wait_done(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
  endtask
  task automatic test_reset();
    #3 rst = 1;
    #1;
    total++;
    if ({bus.step_start, bus.busy, bus.done, bus.error, bus.step_id, bus.step_idx, bus.round_idx} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%0d id=%0d idx=%0d rnd=%0d want all 0", bus.busy, bus.step_id, bus.step_idx, bus.round_idx);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.step_start, bus.busy, bus.error} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got start/busy/error=%b want 000", {bus.step_start, bus.busy, bus.error});
    end
  endtask
  task automatic test_full_run();
    int t0, mism;
    bit seen;
    fix_delay = 1;
    rand_delay = 0;
    recs.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 0;
    wait_done(600, seen);
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL full_done_seen: got %0d want 1", seen); end
    total++;
    if (cyc - t0 !== 3 * NUM_ROUNDS * (2 * LANE_W + LANES + 2) + 1) begin
      bad++;
      $display("FAIL full_done_cycle: got %0d want %0d", cyc - t0, 3 * NUM_ROUNDS * (2 * LANE_W + LANES + 2) + 1);
    end
    repeat (3) @(negedge clk);
    total++;
    if (recs.size() !== PULSES) begin bad++; $display("FAIL full_pulses: got %0d want %0d", recs.size(), PULSES); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    build_exp();
    mism = recs.size() == exp_q.size() ? -1 : recs.size();
    for (int k = 0; k < recs.size() && k < exp_q.size() && mism < 0; k++)
      if (recs[k].id != exp_q[k].id || recs[k].idx != exp_q[k].idx || recs[k].rnd != exp_q[k].rnd) mism = k;
    total++;
    if (mism !== -1) begin
      bad++;
      $display("FAIL full_sequence: first difference at pulse %0d, got %0d pulses want %0d", mism, recs.size(), exp_q.size());
    end
    total++;
    if ({bus.busy, bus.step_idx, bus.round_idx, bus.step_id} !== '0) begin
      bad++;
      $display("FAIL full_idle_after: got busy=%0d idx=%0d rnd=%0d want 0", bus.busy, bus.step_idx, bus.round_idx);
    end
  endtask
  task automatic test_random_delay();
    int t0, mism, want;
    bit seen;
    rand_delay = 1;
    recs.delete();
    delays.delete();
    @(negedge clk);
    bus.start = 1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 0;
    wait_done(2000, seen);
    want = 1;
    foreach (delays[k]) want += delays[k] + 2;
    total++;
    if (seen !== 1'b1 || cyc - t0 !== want) begin
      bad++;
      $display("FAIL rand_done_cycle: got seen=%0d cycle %0d want %0d", seen, cyc - t0, want);
    end
    build_exp();
    mism = recs.size() == exp_q.size() ? -1 : recs.size();
    for (int k = 0; k < recs.size() && k < exp_q.size() && mism < 0; k++)
      if (recs[k].id != exp_q[k].id || recs[k].idx != exp_q[k].idx || recs[k].rnd != exp_q[k].rnd) mism = k;
    total++;
    if (mism !== -1) begin
      bad++;
      $display("FAIL rand_sequence: first difference at pulse %0d, got %0d pulses want %0d", mism, recs.size(), exp_q.size());
    end
    rand_delay = 0;
  endtask
  task automatic test_timeout();
    int n;
    bit seen;
    rec_t lst;
    stall_id = 1;
    stall_idx = 7;
    recs.delete();
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.error;
    end
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL timeout_error: got %0d want 1", seen); end
    lst = recs.size() > 0 ? recs[recs.size() - 1] : '{-1, -1, -1, 0};
    total++;
    if (lst.id !== 1 || lst.idx !== 7 || cyc - lst.cyc !== TIMEOUT + 1) begin
      bad++;
      $display("FAIL timeout_point: got id=%0d idx=%0d after %0d cycles want id=1 idx=7 after %0d", lst.id, lst.idx, cyc - lst.cyc, TIMEOUT + 1);
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %0d want 0", bus.busy); end
    n = recs.size();
    repeat (5) @(negedge clk);
    total++;
    if (recs.size() !== n || bus.error !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got %0d extra pulses error=%0d want 0 and 1", recs.size() - n, bus.error);
    end
    stall_id = 7;
    recs.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    total++;
    if (bus.error !== 1'b0 || bus.step_start !== 1'b1 || bus.step_id !== 3'd0 || bus.step_idx !== '0 || bus.round_idx !== '0) begin
      bad++;
      $display("FAIL timeout_restart: got error=%0d pulse=%0d id=%0d idx=%0d rnd=%0d want 0 1 0 0 0", bus.error, bus.step_start, bus.step_id, bus.step_idx, bus.round_idx);
    end
    wait_done(600, seen);
    repeat (2) @(negedge clk);
    total++;
    if (seen !== 1'b1 || recs.size() !== PULSES) begin
      bad++;
      $display("FAIL timeout_rerun: got done=%0d pulses=%0d want 1 and %0d", seen, recs.size(), PULSES);
    end
  endtask
  task automatic test_abort();
    bit hit;
    int extra;
    @(negedge clk);
    bus.start = 1;
    bus.abort = 1;
    @(negedge clk);
    bus.start = 0;
    bus.abort = 0;
    total++;
    if (bus.busy !== 1'b0 || bus.step_start !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_idle: got busy=%0d pulse=%0d want 0 0", bus.busy, bus.step_start);
    end
    rand_delay = 1;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      hit = bus.step_start && bus.step_id == 3'd3 && bus.step_idx == 5'd2 && bus.round_idx == 1'b1;
      if (!hit) @(negedge clk);
    end
    total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL abort_reach_chi2: got %0d want 1", hit); end
    extra = $urandom_range(0, 2);
    repeat (extra) @(negedge clk);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    total++;
    if ({bus.busy, bus.step_start, bus.error, bus.step_id, bus.step_idx, bus.round_idx} !== '0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%0d id=%0d idx=%0d rnd=%0d want all 0", bus.busy, bus.step_id, bus.step_idx, bus.round_idx);
    end
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt !== 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got done_count=%0d busy=%0d want 0 0", done_cnt, bus.busy);
    end
    rand_delay = 0;
    stall_id = 1;
    stall_idx = $urandom_range(0, LANES - 1);
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit = bus.error;
    end
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    stall_id = 7;
    total++;
    if (hit !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_err: got reached=%0d error=%0d busy=%0d want 1 0 0", hit, bus.error, bus.busy);
    end
  endtask
  task automatic test_back_to_back();
    int t0, gaps;
    bit seen;
    fix_delay = 5;
    recs.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1;
    t0 = cyc;
    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    bus.start = 0;
    total++;
    if (seen !== 1'b1 || cyc - t0 !== PULSES * 7 + 1) begin
      bad++;
      $display("FAIL b2b_done_cycle: got seen=%0d cycle %0d want %0d", seen, cyc - t0, PULSES * 7 + 1);
    end
    repeat (5) @(negedge clk);
    total++;
    if (recs.size() !== PULSES || done_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_counts: got pulses=%0d dones=%0d want %0d 1", recs.size(), done_cnt, PULSES);
    end
    gaps = 0;
    for (int k = 1; k < recs.size(); k++) if (recs[k].cyc - recs[k - 1].cyc != 7) gaps++;
    total++;
    if (gaps !== 0) begin bad++; $display("FAIL b2b_iteration_len: got %0d iterations not 7 cycles want 0", gaps); end
  endtask
  task automatic test_rst_mid();
    bit seen;
    fix_delay = 5;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (7 * $urandom_range(0, 30) + 2) @(negedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({bus.step_start, bus.busy, bus.done, bus.error, bus.step_id, bus.step_idx, bus.round_idx} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got busy=%0d id=%0d idx=%0d rnd=%0d want all 0", bus.busy, bus.step_id, bus.step_idx, bus.round_idx);
    end
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    total++;
    if (done_cnt !== 0 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_quiet: got dones=%0d error=%0d busy=%0d want 0 0 0", done_cnt, bus.error, bus.busy);
    end
    fix_delay = 1;
    recs.delete();
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_done(600, seen);
    repeat (2) @(negedge clk);
    total++;
    if (seen !== 1'b1 || recs.size() !== PULSES || done_cnt !== 1) begin
      bad++;
      $display("FAIL rst_mid_rerun: got done=%0d pulses=%0d dones=%0d want 1 %0d 1", seen, recs.size(), done_cnt, PULSES);
    end
  endtask
  initial begin
    bus.start = 0;
    bus.abort = 0;
    test_reset();
    test_full_run();
    test_random_delay();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
